// File: rtl/alu_sequencer.sv
// alu_sequencer: command front end for the 8-bit combinational ALU.
// Accepts one command at a time and registers its operands onto the ALU bus.
// After SETTLE_CYCLES cycles it captures the ALU result and returns it on a
// valid/ready response channel. Illegal select codes and divide-by-zero are
// rejected without touching the ALU bus.
// Optional feature: define ALU_SEQ_ACCUM_EN to add an accumulator that can
// replace operand A (selected per command by cmd_acc).
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic        cmd_acc,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_sel,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_carry,
  output logic        rsp_err,
  output logic [15:0] cnt_ok,
  output logic [7:0]  cnt_err
);

  localparam logic [3:0] OpAdd      = 4'b0000;
  localparam logic [3:0] OpDiv      = 4'b0011;
  localparam logic [3:0] OpFirstBad = 4'b1010;
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  settle_q, settle_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [3:0]  alu_sel_q, alu_sel_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_carry_q, rsp_carry_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] cnt_ok_q, cnt_ok_d;
  logic [7:0]  cnt_err_q, cnt_err_d;
  logic [7:0]  eff_a;
  logic        cmd_fire;
  logic        rsp_fire;

`ifdef ALU_SEQ_ACCUM_EN
  logic [7:0] acc_q;

  assign eff_a = cmd_acc ? acc_q : cmd_a;

  // Accumulator follows every successful response as it is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= 8'h00;
    end else if (rsp_fire && !rsp_err_q) begin
      acc_q <= rsp_data_q;
    end
  end
`else
  logic unused_cmd_acc;

  assign unused_cmd_acc = cmd_acc;
  assign eff_a          = cmd_a;
`endif

  assign cmd_ready = (state_q == StIdle) && !rst;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_valid = (state_q == StResp);
  assign rsp_fire  = rsp_valid && rsp_ready;

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;
  assign cnt_ok    = cnt_ok_q;
  assign cnt_err   = cnt_err_q;

  // Next-state logic: command screening, settle timing, response handshake.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
    cnt_ok_d    = cnt_ok_q;
    cnt_err_d   = cnt_err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          if (cmd_op >= OpFirstBad) begin
            rsp_data_d  = 8'h00;
            rsp_carry_d = 1'b0;
            rsp_err_d   = 1'b1;
            state_d     = StResp;
          end else if (cmd_op == OpDiv && cmd_b == 8'h00) begin
            // Divide-by-zero always screens on the raw B operand.
            rsp_data_d  = 8'hFF;
            rsp_carry_d = 1'b0;
            rsp_err_d   = 1'b1;
            state_d     = StResp;
          end else begin
            alu_a_d   = eff_a;
            alu_b_d   = cmd_b;
            alu_sel_d = cmd_op;
            settle_d  = 4'd0;
            state_d   = StIssue;
          end
        end
      end
      StIssue: begin
        if (settle_q == SettleLast) begin
          rsp_data_d  = alu_out;
          rsp_carry_d = (alu_sel_q == OpAdd) ? alu_carry : 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = StResp;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      StResp: begin
        if (rsp_fire) begin
          state_d = StIdle;
          if (rsp_err_q) begin
            if (cnt_err_q != 8'hFF) cnt_err_d = cnt_err_q + 8'd1;
          end else begin
            if (cnt_ok_q != 16'hFFFF) cnt_ok_d = cnt_ok_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      settle_q    <= 4'd0;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      alu_sel_q   <= 4'h0;
      rsp_data_q  <= 8'h00;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      cnt_ok_q    <= 16'h0000;
      cnt_err_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
      cnt_ok_q    <= cnt_ok_d;
      cnt_err_q   <= cnt_err_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: one instance with SETTLE_CYCLES=1, one with 3.
// A behavioural ALU model sits on each instance's ALU bus.
module tb_alu_sequencer;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       acc;
    logic [7:0] exp_data;
    logic       exp_carry;
    logic       exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic       rsp_ready = 1'b0;
  logic [3:0] cmd_op = 4'h0;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic       cmd_acc = 1'b0;
  logic       use3 = 1'b0;

  logic        c_ready1, r_valid1, r_carry1, r_err1, a_carry1;
  logic [7:0]  a_a1, a_b1, a_out1, r_data1, e_cnt1;
  logic [3:0]  a_sel1;
  logic [15:0] o_cnt1;
  logic        c_ready3, r_valid3, r_carry3, r_err3, a_carry3;
  logic [7:0]  a_a3, a_b3, a_out3, r_data3, e_cnt3;
  logic [3:0]  a_sel3;
  logic [15:0] o_cnt3;

  // Behavioural ALU: {carry, result}.
  function automatic logic [8:0] alu_model(input logic [3:0] s, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [15:0] p;
    case (s)
      4'h0: alu_model = {1'b0, a} + {1'b0, b};
      4'h1: alu_model = {(a < b), a - b};
      4'h2: begin p = a * b; alu_model = {1'b0, p[7:0]}; end
      4'h3: alu_model = (b == 8'h00) ? 9'h0FF : {1'b0, a / b};
      4'h4: alu_model = {1'b0, a & b};
      4'h5: alu_model = {1'b0, a | b};
      4'h6: alu_model = {1'b0, a[6:0], a[7]};
      4'h7: alu_model = {1'b0, a ^ b};
      4'h8: alu_model = {1'b0, a << 1};
      default: alu_model = {1'b0, a >> 1};
    endcase
  endfunction

  assign {a_carry1, a_out1} = alu_model(a_sel1, a_a1, a_b1);
  assign {a_carry3, a_out3} = alu_model(a_sel3, a_a3, a_b3);

  alu_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid && !use3), .cmd_ready(c_ready1),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
    .alu_a(a_a1), .alu_b(a_b1), .alu_sel(a_sel1), .alu_out(a_out1), .alu_carry(a_carry1),
    .rsp_valid(r_valid1), .rsp_ready(rsp_ready && !use3), .rsp_data(r_data1),
    .rsp_carry(r_carry1), .rsp_err(r_err1), .cnt_ok(o_cnt1), .cnt_err(e_cnt1)
  );

  alu_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid && use3), .cmd_ready(c_ready3),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
    .alu_a(a_a3), .alu_b(a_b3), .alu_sel(a_sel3), .alu_out(a_out3), .alu_carry(a_carry3),
    .rsp_valid(r_valid3), .rsp_ready(rsp_ready && use3), .rsp_data(r_data3),
    .rsp_carry(r_carry3), .rsp_err(r_err3), .cnt_ok(o_cnt3), .cnt_err(e_cnt3)
  );

  // Selected-instance view.
  logic        cmd_ready, rsp_valid, rsp_carry, rsp_err;
  logic [7:0]  alu_a, alu_b, rsp_data, cnt_err;
  logic [3:0]  alu_sel;
  logic [15:0] cnt_ok;
  always_comb begin
    cmd_ready = use3 ? c_ready3 : c_ready1;
    rsp_valid = use3 ? r_valid3 : r_valid1;
    rsp_carry = use3 ? r_carry3 : r_carry1;
    rsp_err   = use3 ? r_err3 : r_err1;
    alu_a     = use3 ? a_a3 : a_a1;
    alu_b     = use3 ? a_b3 : a_b1;
    alu_sel   = use3 ? a_sel3 : a_sel1;
    rsp_data  = use3 ? r_data3 : r_data1;
    cnt_ok    = use3 ? o_cnt3 : o_cnt1;
    cnt_err   = use3 ? e_cnt3 : e_cnt1;
  end

  int n_pass = 0;
  int n_total = 0;

  // Model state for the selected instance.
  logic [7:0]  m_a, m_b, m_acc;
  logic [3:0]  m_sel;
  logic [15:0] m_ok;
  logic [7:0]  m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_a = 8'h00; m_b = 8'h00; m_sel = 4'h0; m_acc = 8'h00; m_ok = 16'h0; m_err = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one command, check latency, response fields, bus and counters.
  task automatic run_vec(input vec_t v, input int settle, input string tag);
    int  n;
    logic legal;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    check({tag, " ready"}, cmd_ready, 1'b1);
    cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_acc = v.acc; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_acc = 1'b0;
    legal = !(v.op >= 4'hA) && !(v.op == 4'h3 && v.b == 8'h00);
    if (legal) begin
`ifdef ALU_SEQ_ACCUM_EN
      m_a = v.acc ? m_acc : v.a;
`else
      m_a = v.a;
`endif
      m_b = v.b; m_sel = v.op;
    end
    check({tag, " alu_a"}, alu_a, m_a);
    check({tag, " alu_b"}, alu_b, m_b);
    check({tag, " alu_sel"}, alu_sel, m_sel);
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    check({tag, " latency"}, n, legal ? settle : 0);
    check({tag, " rsp_data"}, rsp_data, v.exp_data);
    check({tag, " rsp_carry"}, rsp_carry, v.exp_carry);
    check({tag, " rsp_err"}, rsp_err, v.exp_err);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    if (v.exp_err) m_err++;
    else begin m_ok++; m_acc = v.exp_data; end
    check({tag, " cnt_ok"}, cnt_ok, m_ok);
    check({tag, " cnt_err"}, cnt_err, m_err);
    check({tag, " ready after"}, cmd_ready, 1'b1);
    check({tag, " valid after"}, rsp_valid, 1'b0);
  endtask

  vec_t vecs[13];
  vec_t bp;

  initial begin
`ifdef ALU_SEQ_ACCUM_EN
    logic [7:0] acc_exp = 8'h20;
`else
    logic [7:0] acc_exp = 8'h00;
`endif
    //           op     a      b      acc   data   c     err
    vecs[0]  = '{4'h0, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0};
    vecs[1]  = '{4'h3, 8'h40, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[2]  = '{4'hC, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[3]  = '{4'hF, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[4]  = '{4'hA, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[5]  = '{4'h1, 8'h03, 8'h0A, 1'b0, 8'hF9, 1'b0, 1'b0};
    vecs[6]  = '{4'h2, 8'h10, 8'h11, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[7]  = '{4'h3, 8'h64, 8'h07, 1'b0, 8'h0E, 1'b0, 1'b0};
    vecs[8]  = '{4'h4, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[9]  = '{4'h0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[10] = '{4'h9, 8'h80, 8'h00, 1'b0, 8'h40, 1'b0, 1'b0};
    vecs[11] = '{4'h0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[12] = '{4'h2, 8'h00, 8'h04, 1'b1, acc_exp, 1'b0, 1'b0};

    model_reset();
    #2;
    check("reset cmd_ready", cmd_ready, 1'b0);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset alu_sel", alu_sel, 4'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("release cmd_ready", cmd_ready, 1'b1);
    tick();

    for (int i = 0; i < 13; i++) run_vec(vecs[i], 1, $sformatf("v%0d", i));

    // Backpressure on the SETTLE_CYCLES=3 instance.
    use3 = 1'b1;
    model_reset();
    #1;
    cmd_op = 4'h6; cmd_a = 8'h81; cmd_b = 8'h00; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("bp alu_sel", alu_sel, 4'h6);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp early valid", rsp_valid, 1'b0);
    end
    tick();
    check("bp valid at settle", rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cmd_op = 4'h0; cmd_a = 8'h11; cmd_b = 8'h22; cmd_valid = 1'b1;
      end
      check("bp hold data", rsp_data, 8'h03);
      check("bp hold valid", rsp_valid, 1'b1);
      check("bp cmd_ready", cmd_ready, 1'b0);
      tick();
      cmd_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp cnt_ok", cnt_ok, 16'd1);
    check("bp ready after", cmd_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp pulse not consumed", rsp_valid, 1'b0);
    end
    check("bp alu_a kept", alu_a, 8'h81);

    // Reset in the middle of ISSUE.
    cmd_op = 4'h0; cmd_a = 8'h07; cmd_b = 8'h09; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rst alu_a", alu_a, 8'h00);
    check("rst alu_b", alu_b, 8'h00);
    check("rst alu_sel", alu_sel, 4'h0);
    check("rst rsp_valid", rsp_valid, 1'b0);
    check("rst rsp_data", rsp_data, 8'h00);
    check("rst cnt_ok", cnt_ok, 16'd0);
    check("rst cnt_err", cnt_err, 8'd0);
    check("rst cmd_ready", cmd_ready, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("rst ready after release", cmd_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst no stray valid", rsp_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
